// File: rtl/cpu_pkg.sv
// Shared types and constants for the ARM-subset processor front end.
// Holds the fetch FSM state type and the decode-field bit positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam int COND_MSB       = 31;
    localparam int OP_MSB         = 27;
    localparam int FUNCT_MSB      = 25;
    localparam int RD_MSB         = 15;
    localparam int PC_READ_OFFSET = 8;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with instruction memory,
// holds the fetched word and redirects the PC when the held instruction retires.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [31:0] Result,
    output logic        instr_valid,
    output logic [31:0] Instr,
    output logic [3:0]  Cond,
    output logic [1:0]  Op,
    output logic [5:0]  Funct,
    output logic [3:0]  Rd,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8,
    output logic [31:0] retire_count
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    logic [31:0]  retire_count_q, retire_count_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            instr_q        <= 32'd0;
            instr_valid_q  <= 1'b0;
            retire_count_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            instr_q        <= instr_d;
            instr_valid_q  <= instr_valid_d;
            retire_count_q <= retire_count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        instr_valid_d  = instr_valid_q;
        retire_count_d = retire_count_q;
        imem_req       = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    // Redirect targets are forced onto a word boundary.
                    pc_d           = PCSrc ? (Result & 32'hFFFF_FFFC)
                                           : pc_q + 32'(PC_STEP);
                    instr_valid_d  = 1'b0;
                    retire_count_d = retire_count_q + 32'd1;
                    state_d        = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_addr    = pc_q;
    assign instr_valid  = instr_valid_q;
    assign Instr        = instr_q;
    assign Cond         = instr_q[COND_MSB -: 4];
    assign Op           = instr_q[OP_MSB -: 2];
    assign Funct        = instr_q[FUNCT_MSB -: 6];
    assign Rd           = instr_q[RD_MSB -: 4];
    assign PC           = pc_q;
    assign PCPlus8      = pc_q + 32'(PC_READ_OFFSET);
    assign retire_count = retire_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random stimulus,
// every cycle checked against a transaction-level model of the fetch stage.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        stall;
    logic        PCSrc;
    logic [31:0] Result;
    logic        instr_valid;
    logic [31:0] Instr;
    logic [3:0]  Cond;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic [3:0]  Rd;
    logic [31:0] PC;
    logic [31:0] PCPlus8;
    logic [31:0] retire_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a post-reset bubble, then alternating "waiting for a word" and
    // "holding a word" phases.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic [31:0] m_count;
    logic        m_bubble;

    fetch_unit dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .stall(stall), .PCSrc(PCSrc), .Result(Result),
        .instr_valid(instr_valid), .Instr(Instr),
        .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .PC(PC), .PCPlus8(PCPlus8), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
            m_count = 32'h0; m_bubble = 1'b1;
        end else if (m_bubble) begin
            m_bubble = 1'b0;
        end else if (!m_valid) begin
            if (imem_valid) begin
                m_instr = imem_rdata;
                m_valid = 1'b1;
            end
        end else if (!stall) begin
            m_pc    = PCSrc ? (Result & ~32'd3) : m_pc + 32'd4;
            m_count = m_count + 32'd1;
            m_valid = 1'b0;
        end
    endtask

    task automatic check_all();
        logic exp_req;
        exp_req = !m_bubble && !m_valid;
        chk("req", 32'(imem_req), 32'(exp_req));
        if (exp_req) chk("addr", imem_addr, m_pc);
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("Instr", Instr, m_instr);
        chk("Cond", 32'(Cond), (m_instr >> 28) & 32'hF);
        chk("Op", 32'(Op), (m_instr >> 26) & 32'h3);
        chk("Funct", 32'(Funct), (m_instr >> 20) & 32'h3F);
        chk("Rd", 32'(Rd), (m_instr >> 12) & 32'hF);
        chk("PC", PC, m_pc);
        chk("PCPlus8", PCPlus8, m_pc + 32'd8);
        chk("retire_count", retire_count, m_count);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
        $display("t=%0t rst=%0b req=%0b addr=%h ivld=%0b stall=%0b pcsrc=%0b valid=%0b Instr=%h PC=%h cnt=%0d",
                 $time, rst, imem_req, imem_addr, imem_valid, stall, PCSrc,
                 instr_valid, Instr, PC, retire_count);
    endtask

    initial begin
        rst = 1'b0; imem_valid = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; PCSrc = 1'b0; Result = 32'h0;
        step(); step();

        // Reset release with zero-wait memory
        rst = 1'b1; imem_valid = 1'b1; imem_rdata = 32'hE280_0004;
        chk("c1_req", 32'(imem_req), 32'd0);
        step();
        chk("c2_req", 32'(imem_req), 32'd1);
        chk("c2_addr", imem_addr, 32'h0);
        step();
        chk("c3_valid", 32'(instr_valid), 32'd1);
        chk("c3_cond", 32'(Cond), 32'hE);
        chk("c3_op", 32'(Op), 32'd0);
        chk("c3_funct", 32'(Funct), 32'b101000);
        chk("c3_rd", 32'(Rd), 32'd0);
        chk("c3_pc8", PCPlus8, 32'd8);

        // Sequential run
        step(); chk("seq_addr4", imem_addr, 32'h4);
        step();
        step(); chk("seq_addr8", imem_addr, 32'h8);
        step();
        step(); chk("seq_count3", retire_count, 32'd3);

        // Wait-state memory
        imem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ws_req", 32'(imem_req), 32'd1);
            chk("ws_addr", imem_addr, 32'hC);
            chk("ws_ivalid", 32'(instr_valid), 32'd0);
        end
        imem_valid = 1'b1;
        step(); chk("ws_valid", 32'(instr_valid), 32'd1);

        // Stall in HOLD with a pending redirect
        stall = 1'b1; PCSrc = 1'b1; Result = 32'h100;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("st_pc", PC, 32'hC);
            chk("st_valid", 32'(instr_valid), 32'd1);
        end
        stall = 1'b0;
        step();
        chk("st_addr", imem_addr, 32'h100);
        chk("st_count", retire_count, 32'd4);
        PCSrc = 1'b0;
        step();

        // Misaligned redirect, then wrap
        PCSrc = 1'b1; Result = 32'h203;
        step(); chk("mis_addr", imem_addr, 32'h200);
        step();
        Result = 32'hFFFF_FFFF;
        step(); chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
        step();
        PCSrc = 1'b0;
        step(); chk("wrap_addr", imem_addr, 32'h0);

        // Reset while a response arrives in FETCH
        imem_valid = 1'b1; imem_rdata = 32'h1234_5678; rst = 1'b0;
        step();
        chk("rf_valid", 32'(instr_valid), 32'd0);
        chk("rf_pc", PC, 32'h0);
        chk("rf_count", retire_count, 32'd0);
        chk("rf_instr", Instr, 32'h0);
        rst = 1'b1;
        chk("rf_idle", 32'(imem_req), 32'd0);
        step();
        chk("rf_restart", 32'(imem_req), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 59) != 0);
            imem_valid = ($urandom_range(0, 2) != 0);
            stall      = ($urandom_range(0, 3) == 0);
            PCSrc      = $urandom_range(0, 1) == 1;
            Result     = $urandom;
            imem_rdata = $urandom;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
